// File: rtl/vector_regfile_if.sv
// Register-file access bundle between the datapath (master) and the vector register file (slave).
// Carries the read address/data ports and the byte-strobed write ports.
interface vector_regfile_if #(
    parameter int NRD  = 8,
    parameter int NWR  = 4,
    parameter int VLEN = 128,
    parameter int AW   = 5
);
    logic [NRD-1:0][AW-1:0]     vsi_rf_raddr;
    logic [NRD-1:0][VLEN-1:0]   vsi_rf_rdata;
    logic [NWR-1:0][AW-1:0]     vsi_rf_waddr;
    logic [NWR-1:0][VLEN/8-1:0] vsi_rf_wstrb;
    logic [NWR-1:0][VLEN-1:0]   vsi_rf_wdata;

    modport master (
        output vsi_rf_raddr,
        output vsi_rf_waddr,
        output vsi_rf_wstrb,
        output vsi_rf_wdata,
        input  vsi_rf_rdata
    );

    modport slave (
        input  vsi_rf_raddr,
        input  vsi_rf_waddr,
        input  vsi_rf_wstrb,
        input  vsi_rf_wdata,
        output vsi_rf_rdata
    );
endinterface

// File: rtl/vector_regfile.sv
// Vector register file: NRD combinational read ports, NWR byte-strobed write ports,
// and a one-register-per-cycle clear engine gating availability via rf_ready.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_CLEAR | zeroing reg[r_clr_cnt] each cycle; writes dropped, rdata=0
//  ST_READY | normal read/write operation; rf_ready=1
module vector_regfile #(
    parameter int NREG   = 32,
    parameter int VLEN   = 128,
    parameter int NRD    = 8,
    parameter int NWR    = 4,
    parameter int BYPASS = 0
) (
    input  logic             vsi_clk,
    input  logic             vsi_rst,
    vector_regfile_if.slave  rf,
    input  logic             rf_clear_req,
    output logic             rf_ready
);
    localparam int NB = VLEN / 8;
    localparam int CW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_clr_cnt;
    logic [CW-1:0]   w_clr_cnt_nxt;

    logic [VLEN-1:0] r_mem    [NREG];
    logic [VLEN-1:0] w_merged [NREG];
    logic [NRD-1:0][VLEN-1:0] w_rdata;

    always_ff @(posedge vsi_clk) begin
        if (vsi_rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == CW'(NREG - 1)) begin
                    w_state_nxt   = ST_READY;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (rf_clear_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign rf_ready = (r_state == ST_READY);

    // Post-write image of every register; later ports overwrite earlier ones per byte.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_merged[r] = r_mem[r];
            for (int w = 0; w < NWR; w++) begin
                if (int'(rf.vsi_rf_waddr[w]) == r) begin
                    for (int b = 0; b < NB; b++) begin
                        if (rf.vsi_rf_wstrb[w][b]) begin
                            w_merged[r][b*8 +: 8] = rf.vsi_rf_wdata[w][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Storage carries no reset; its contents are meaningless until a clear pass completes.
    always_ff @(posedge vsi_clk) begin
        if (!vsi_rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else begin
                for (int r = 0; r < NREG; r++) begin
                    r_mem[r] <= w_merged[r];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_rdata[p] = '0;
            if (r_state == ST_READY && int'(rf.vsi_rf_raddr[p]) < NREG) begin
                if (BYPASS != 0) begin
                    w_rdata[p] = w_merged[rf.vsi_rf_raddr[p]];
                end else begin
                    w_rdata[p] = r_mem[rf.vsi_rf_raddr[p]];
                end
            end
        end
    end

    assign rf.vsi_rf_rdata = w_rdata;
endmodule
